// File: rtl/ac_motor_vector_pwm_if.sv
// Bus between the dwell-time stage / gate driver and the space-vector PWM core.
// Names carry the core's view: i_ signals enter the core, o_ signals leave it.
interface ac_motor_vector_pwm_if;
    logic        i_enable;
    logic [14:0] i_tLow;
    logic [14:0] i_tHigh;
    logic [2:0]  i_sector;
    logic        o_sample;
    logic        o_pwmUH;
    logic        o_pwmVH;
    logic        o_pwmWH;
    logic        o_pwmUL;
    logic        o_pwmVL;
    logic        o_pwmWL;

    modport master (
        output i_enable, i_tLow, i_tHigh, i_sector,
        input  o_sample, o_pwmUH, o_pwmVH, o_pwmWH, o_pwmUL, o_pwmVL, o_pwmWL
    );

    modport slave (
        input  i_enable, i_tLow, i_tHigh, i_sector,
        output o_sample, o_pwmUH, o_pwmVH, o_pwmWH, o_pwmUL, o_pwmVL, o_pwmWL
    );
endinterface

// File: rtl/ac_motor_vector_pwm.sv
// Space-vector PWM: zero / V_k / V_k+1 / zero sequence per sampling period, plus SAMPLE strobe.
// Define AC_MOTOR_VECTOR_PWM_DEADTIME_EN to insert DEADTIME cycles of dead time per phase.
module ac_motor_vector_pwm #(
    parameter int PERIOD = 20000
`ifdef AC_MOTOR_VECTOR_PWM_DEADTIME_EN
    , parameter int DEADTIME = 100
`endif
) (
    input logic                  CLK,
    input logic                  RESET_N,
    ac_motor_vector_pwm_if.slave pwmBus
);

    typedef enum logic [2:0] {IDLE, ZERO0, ACT1, ACT2, ZERO7} state_t;

    localparam logic [15:0] W_PERIOD = 16'(PERIOD);
    localparam logic [14:0] K_LAST   = 15'(PERIOD - 1);

    state_t      r_state;
    logic [14:0] r_k;
    logic        r_primed;
    logic        r_sample;
    logic [14:0] r_tl;
    logic [14:0] r_th;
    logic [2:0]  r_sec;
    logic [2:0]  r_pwmH;
    logic [2:0]  r_pwmL;

    logic        w_running;
    logic        w_latch;
    logic        w_goRun;
    logic [14:0] w_kNext;
    logic [15:0] w_kNext16;
    logic [14:0] w_tlSel;
    logic [14:0] w_thSel;
    logic [2:0]  w_secSel;
    logic [15:0] w_tlc;
    logic [15:0] w_rem;
    logic [15:0] w_thc;
    logic [15:0] w_t0;
    logic [15:0] w_b1;
    logic [15:0] w_b2;
    logic [15:0] w_b3;
    state_t      w_segNext;
    logic [2:0]  w_vk;
    logic [2:0]  w_vk1;
    logic        w_secValid;
    logic [2:0]  w_vecNext;

    // Everything registered is computed from the cycle about to start, so the
    // period's first cycle already uses the values latched on that same edge.
    assign w_running = (r_state != IDLE);
    assign w_latch   = r_primed | (w_running & (r_k == K_LAST));
    assign w_goRun   = pwmBus.i_enable & (w_running | r_primed);
    assign w_kNext   = w_latch ? 15'd0 : (r_k + 15'd1);
    assign w_kNext16 = {1'b0, w_kNext};

    assign w_tlSel  = w_latch ? pwmBus.i_tLow   : r_tl;
    assign w_thSel  = w_latch ? pwmBus.i_tHigh  : r_th;
    assign w_secSel = w_latch ? pwmBus.i_sector : r_sec;

    assign w_tlc = ({1'b0, w_tlSel} > W_PERIOD) ? W_PERIOD : {1'b0, w_tlSel};
    assign w_rem = W_PERIOD - w_tlc;
    assign w_thc = ({1'b0, w_thSel} > w_rem) ? w_rem : {1'b0, w_thSel};
    assign w_t0  = w_rem - w_thc;
    assign w_b1  = {1'b0, w_t0[15:1]};
    assign w_b2  = w_b1 + w_tlc;
    assign w_b3  = w_b2 + w_thc;

    always_comb begin
        if (w_kNext16 < w_b1) begin
            w_segNext = ZERO0;
        end else if (w_kNext16 < w_b2) begin
            w_segNext = ACT1;
        end else if (w_kNext16 < w_b3) begin
            w_segNext = ACT2;
        end else begin
            w_segNext = ZERO7;
        end
    end

    // Vector bits are ordered {U, V, W}.
    always_comb begin
        w_vk       = 3'b000;
        w_vk1      = 3'b000;
        w_secValid = 1'b1;
        case (w_secSel)
            3'd1: begin w_vk = 3'b100; w_vk1 = 3'b110; end
            3'd2: begin w_vk = 3'b110; w_vk1 = 3'b010; end
            3'd3: begin w_vk = 3'b010; w_vk1 = 3'b011; end
            3'd4: begin w_vk = 3'b011; w_vk1 = 3'b001; end
            3'd5: begin w_vk = 3'b001; w_vk1 = 3'b101; end
            3'd6: begin w_vk = 3'b101; w_vk1 = 3'b100; end
            default: w_secValid = 1'b0;
        endcase
    end

    always_comb begin
        w_vecNext = 3'b000;
        if (w_secValid) begin
            case (w_segNext)
                ACT1:    w_vecNext = w_vk;
                ACT2:    w_vecNext = w_vk1;
                ZERO7:   w_vecNext = 3'b111;
                default: w_vecNext = 3'b000;
            endcase
        end
    end

    // r_primed marks the extra SAMPLE cycle after ENABLE rises; it behaves like
    // cycle PERIOD-1 so the first latch happens on its closing edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= IDLE;
            r_k      <= 15'd0;
            r_primed <= 1'b0;
            r_sample <= 1'b0;
            r_tl     <= 15'd0;
            r_th     <= 15'd0;
            r_sec    <= 3'd0;
        end else if (!pwmBus.i_enable) begin
            r_state  <= IDLE;
            r_k      <= 15'd0;
            r_primed <= 1'b0;
            r_sample <= 1'b0;
        end else if (!w_running && !r_primed) begin
            r_primed <= 1'b1;
            r_sample <= 1'b1;
        end else begin
            r_primed <= 1'b0;
            r_k      <= w_kNext;
            r_state  <= w_segNext;
            r_sample <= (w_kNext == K_LAST);
            if (w_latch) begin
                r_tl  <= pwmBus.i_tLow;
                r_th  <= pwmBus.i_tHigh;
                r_sec <= pwmBus.i_sector;
            end
        end
    end

`ifdef AC_MOTOR_VECTOR_PWM_DEADTIME_EN
    localparam int             DT_W    = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME);
    localparam logic           DT_NONE = (DEADTIME == 0);

    logic [2:0]      r_want;
    logic [DT_W-1:0] r_dtCnt [3];

    // A level change drops both switches at once and restarts the phase's
    // countdown; a change arriving mid-countdown re-arms it for the new level.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_want <= 3'b000;
            r_pwmH <= 3'b000;
            r_pwmL <= 3'b000;
            for (int p = 0; p < 3; p++) r_dtCnt[p] <= '0;
        end else if (!w_goRun) begin
            r_want <= 3'b000;
            r_pwmH <= 3'b000;
            r_pwmL <= 3'b000;
            for (int p = 0; p < 3; p++) r_dtCnt[p] <= '0;
        end else if (!w_running) begin
            r_want <= w_vecNext;
            r_pwmH <= w_vecNext;
            r_pwmL <= ~w_vecNext;
            for (int p = 0; p < 3; p++) r_dtCnt[p] <= '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (w_vecNext[p] != r_want[p]) begin
                    r_want[p]  <= w_vecNext[p];
                    r_dtCnt[p] <= DT_LOAD;
                    r_pwmH[p]  <= DT_NONE & w_vecNext[p];
                    r_pwmL[p]  <= DT_NONE & ~w_vecNext[p];
                end else if (r_dtCnt[p] != '0) begin
                    r_dtCnt[p] <= r_dtCnt[p] - DT_W'(1);
                    if (r_dtCnt[p] == DT_W'(1)) begin
                        r_pwmH[p] <= r_want[p];
                        r_pwmL[p] <= ~r_want[p];
                    end
                end
            end
        end
    end
`else
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pwmH <= 3'b000;
            r_pwmL <= 3'b000;
        end else if (!w_goRun) begin
            r_pwmH <= 3'b000;
            r_pwmL <= 3'b000;
        end else begin
            r_pwmH <= w_vecNext;
            r_pwmL <= ~w_vecNext;
        end
    end
`endif

    assign pwmBus.o_sample = r_sample;
    assign pwmBus.o_pwmUH  = r_pwmH[2];
    assign pwmBus.o_pwmVH  = r_pwmH[1];
    assign pwmBus.o_pwmWH  = r_pwmH[0];
    assign pwmBus.o_pwmUL  = r_pwmL[2];
    assign pwmBus.o_pwmVL  = r_pwmL[1];
    assign pwmBus.o_pwmWL  = r_pwmL[0];

endmodule
